// File: rtl/rom_stream_reader.sv
// Parametrised synchronous-read ROM with a block sequencer that streams
// base..base+length-1 over a valid/ready handshake, optionally looping.
module rom_stream_reader #(
  parameter int                          DATA_WIDTH = 8,
  parameter int                          DEPTH      = 16,
  parameter int                          ADDR_WIDTH = 4,
  parameter string                       INIT_FILE  = "rom_init.hex",
  parameter bit                          LOOP       = 1'b0,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_IMAGE = '0
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FETCH   = 2'd1,
    S_PRESENT = 2'd2
  } state_t;

  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  // INIT_IMAGE supplies the ROM contents word by word; unlisted words are zero
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      r_mem[i] = INIT_IMAGE[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH:0]   r_rem;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH:0]   r_len;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic [ADDR_WIDTH:0]   w_rem_nxt;
  logic [ADDR_WIDTH-1:0] w_base_nxt;
  logic [ADDR_WIDTH:0]   w_len_nxt;
  logic                  w_done_nxt;
  logic                  w_load;
  logic [ADDR_WIDTH-1:0] w_base_mod;
  logic [ADDR_WIDTH-1:0] w_addr_inc;

  assign w_base_mod = ADDR_WIDTH'(32'(base_addr) % 32'(DEPTH));
  assign w_addr_inc = (r_addr == ADDR_WIDTH'(DEPTH - 1)) ? '0 : r_addr + ADDR_WIDTH'(1);

  // Next-state and datapath-update decode; abort overrides the state and done decision
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_rem_nxt   = r_rem;
    w_base_nxt  = r_base;
    w_len_nxt   = r_len;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          if (length != '0) begin
            w_base_nxt  = w_base_mod;
            w_len_nxt   = length;
            w_addr_nxt  = w_base_mod;
            w_rem_nxt   = length;
            w_state_nxt = S_FETCH;
          end else begin
            w_done_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        w_load      = 1'b1;
        w_state_nxt = S_PRESENT;
      end
      S_PRESENT: begin
        if (out_ready) begin
          w_rem_nxt  = r_rem - (ADDR_WIDTH+1)'(1);
          w_addr_nxt = w_addr_inc;
          if (r_rem > (ADDR_WIDTH+1)'(1)) begin
            w_state_nxt = S_FETCH;
          end else if (LOOP) begin
            w_done_nxt  = 1'b1;
            w_addr_nxt  = r_base;
            w_rem_nxt   = r_len;
            w_state_nxt = S_FETCH;
          end else begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_PRESENT;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // a transfer in the abort cycle still advances addr/remaining
    if (abort) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
    end else begin
      w_done_nxt = w_done_nxt;
    end
  end

  // State, datapath and registered outputs; outputs follow the next state so they align with it
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_rem   <= '0;
      r_base  <= '0;
      r_len   <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_rem   <= w_rem_nxt;
      r_base  <= w_base_nxt;
      r_len   <= w_len_nxt;
      if (w_load) begin
        r_data <= r_mem[r_addr];
      end else begin
        r_data <= r_data;
      end
      r_valid <= (w_state_nxt == S_PRESENT);
      r_busy  <= (w_state_nxt != S_IDLE);
      r_done  <= w_done_nxt;
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_rom_stream_reader.sv
// Scoreboard bench: directed commands push expected words; per-DUT monitors pop on each handshake.
module tb_rom_stream_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic       a_start, a_abort, a_ready, a_valid, a_busy, a_done;
  logic [3:0] a_base;
  logic [4:0] a_len;
  logic [7:0] a_data;
  logic       b_start, b_abort, b_ready, b_valid, b_busy, b_done;
  logic [3:0] b_base;
  logic [4:0] b_len;
  logic [7:0] b_data;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];

  localparam logic [127:0] IMG_A = {8'hAF, 8'hAE, 8'hAD, 8'hAC, 8'hAB, 8'hAA,
                                    {9{8'h8B}}, 8'h42};
  localparam logic [79:0]  IMG_B = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05,
                                    8'h04, 8'h03, 8'h02, 8'h01, 8'h00};

  rom_stream_reader #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4), .INIT_FILE(""),
                      .LOOP(1'b0), .INIT_IMAGE(IMG_A)) u_a (
    .CLOCK(clk), .RESET(rst), .start(a_start), .base_addr(a_base), .length(a_len),
    .abort(a_abort), .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
    .busy(a_busy), .done(a_done));

  rom_stream_reader #(.DATA_WIDTH(8), .DEPTH(10), .ADDR_WIDTH(4), .INIT_FILE(""),
                      .LOOP(1'b1), .INIT_IMAGE(IMG_B)) u_b (
    .CLOCK(clk), .RESET(rst), .start(b_start), .base_addr(b_base), .length(b_len),
    .abort(b_abort), .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
    .busy(b_busy), .done(b_done));

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event seen, required absent", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(input int budget, output int k);
    k = 0;
    while (!a_done && k < budget) begin
      tick();
      k++;
    end
    if (!a_done) fail_now("a_done_timeout");
  endtask

  logic       a_prev_stall, a_prev_done, b_prev_stall, b_prev_done;
  logic [7:0] a_prev_data, b_prev_data;

  // Monitor A: pop/compare on handshake, hold while stalled, single-cycle done
  always @(negedge clk) begin
    if (rst) begin
      a_prev_stall <= 1'b0;
      a_prev_done  <= 1'b0;
    end else begin
      if (a_prev_stall && a_valid) check("a_hold", a_data, a_prev_data);
      if (a_done && a_prev_done) fail_now("a_done_width");
      if (a_valid && a_ready) begin
        if (exp_a.size() == 0) fail_now("a_unexpected_word");
        else check("a_word", a_data, exp_a.pop_front());
      end
      a_prev_stall <= a_valid && !a_ready;
      a_prev_data  <= a_data;
      a_prev_done  <= a_done;
    end
  end

  // Monitor B: same checks for the looping instance
  always @(negedge clk) begin
    if (rst) begin
      b_prev_stall <= 1'b0;
      b_prev_done  <= 1'b0;
    end else begin
      if (b_prev_stall && b_valid) check("b_hold", b_data, b_prev_data);
      if (b_done && b_prev_done) fail_now("b_done_width");
      if (b_valid && b_ready) begin
        if (exp_b.size() == 0) fail_now("b_unexpected_word");
        else check("b_word", b_data, exp_b.pop_front());
      end
      b_prev_stall <= b_valid && !b_ready;
      b_prev_data  <= b_data;
      b_prev_done  <= b_done;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cnt;
    int first;
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_ready = 1'b0; a_base = 4'd0; a_len = 5'd0;
    b_start = 1'b0; b_abort = 1'b0; b_ready = 1'b0; b_base = 4'd0; b_len = 5'd0;
    repeat (3) tick();
    check("rst_a_valid", a_valid, 0); check("rst_a_busy", a_busy, 0);
    check("rst_a_done", a_done, 0);   check("rst_a_data", a_data, 0);
    check("rst_b_valid", b_valid, 0); check("rst_b_busy", b_busy, 0);
    check("rst_b_done", b_done, 0);   check("rst_b_data", b_data, 0);
    rst = 1'b0;
    tick();

    // A1: ten words 0x42,0x8B x9 at full rate
    exp_a.push_back(8'h42);
    for (int i = 0; i < 9; i++) exp_a.push_back(8'h8B);
    a_base = 4'd0; a_len = 5'd10; a_ready = 1'b1; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a1_busy_after_start", a_busy, 1);
    check("a1_valid_after_start", a_valid, 0);
    tick();
    check("a1_first_valid", a_valid, 1);
    check("a1_first_data", a_data, 8'h42);
    wait_done_a(40, k);
    check("a1_done_cycle", k + 1, 20);
    check("a1_busy_at_done", a_busy, 0);
    check("a1_queue_empty", exp_a.size(), 0);
    tick();
    check("a1_done_one_cycle", a_done, 0);

    // A2: wrap at power-of-two depth
    exp_a.push_back(8'hAF); exp_a.push_back(8'h42); exp_a.push_back(8'h8B);
    a_base = 4'd15; a_len = 5'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a(20, k);
    check("a2_done_cycle", k, 6);
    check("a2_queue_empty", exp_a.size(), 0);
    tick();

    // A3: backpressure 0,0,1 per word
    a_ready = 1'b0;
    exp_a.push_back(8'h8B); exp_a.push_back(8'hAA); exp_a.push_back(8'hAB);
    a_base = 4'd9; a_len = 5'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    for (int w = 0; w < 3; w++) begin
      tick();
      check("a3_valid", a_valid, 1);
      tick();
      tick();
      a_ready = 1'b1;
      tick();
      a_ready = 1'b0;
    end
    check("a3_done", a_done, 1);
    check("a3_busy", a_busy, 0);
    check("a3_queue_empty", exp_a.size(), 0);
    tick();

    // A4: empty command
    a_ready = 1'b1; a_len = 5'd0; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a4_done", a_done, 1);
    check("a4_busy", a_busy, 0);
    check("a4_valid", a_valid, 0);
    tick();
    check("a4_done_low", a_done, 0);
    check("a4_busy_low", a_busy, 0);

    // A5: start while busy is ignored
    a_ready = 1'b0;
    exp_a.push_back(8'h42); exp_a.push_back(8'h8B);
    a_base = 4'd0; a_len = 5'd2; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    a_base = 4'd5; a_len = 5'd7; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    check("a5_busy", a_busy, 1);
    check("a5_data_held", a_data, 8'h42);
    a_ready = 1'b1;
    wait_done_a(20, k);
    check("a5_done_cycle", k, 3);
    check("a5_queue_empty", exp_a.size(), 0);
    repeat (4) tick();
    check("a5_idle", a_busy, 0);

    // A6: reset during PRESENT, then a normal command
    a_ready = 1'b0;
    exp_a.push_back(8'h42); exp_a.push_back(8'h8B); exp_a.push_back(8'h8B);
    a_base = 4'd0; a_len = 5'd3; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    tick();
    check("a6_valid_before_rst", a_valid, 1);
    rst = 1'b1;
    tick();
    check("a6_rst_valid", a_valid, 0); check("a6_rst_busy", a_busy, 0);
    check("a6_rst_done", a_done, 0);   check("a6_rst_data", a_data, 0);
    rst = 1'b0;
    exp_a.delete();
    a_ready = 1'b1;
    exp_a.push_back(8'hAA); exp_a.push_back(8'hAB);
    a_base = 4'd10; a_len = 5'd2; a_start = 1'b1;
    tick();
    a_start = 1'b0;
    wait_done_a(20, k);
    check("a6_done_cycle", k, 4);
    check("a6_queue_empty", exp_a.size(), 0);
    tick();

    // B1: loop with wrap at DEPTH=10, then abort
    b_ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      exp_b.push_back(8'd8); exp_b.push_back(8'd9);
      exp_b.push_back(8'd0); exp_b.push_back(8'd1);
    end
    b_base = 4'd8; b_len = 5'd4; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 0; first = -1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (b_done) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    check("b1_done_count", cnt, 2);
    check("b1_first_done", first, 8);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    check("b1_abort_valid", b_valid, 0);
    check("b1_abort_busy", b_busy, 0);
    check("b1_abort_done", b_done, 0);
    check("b1_queue_empty", exp_b.size(), 0);
    tick();
    check("b1_stays_idle", b_busy, 0);

    // B2: abort coincident with the final transfer suppresses done
    exp_b.push_back(8'd0); exp_b.push_back(8'd1); exp_b.push_back(8'd2);
    b_base = 4'd0; b_len = 5'd3; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 0;
    repeat (5) begin
      tick();
      if (b_done) cnt++;
    end
    check("b2_last_word", b_data, 8'd2);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    check("b2_no_done", b_done, 0);
    check("b2_valid", b_valid, 0);
    check("b2_busy", b_busy, 0);
    check("b2_done_count", cnt, 0);
    check("b2_queue_empty", exp_b.size(), 0);
    tick();
    check("b2_done_still_low", b_done, 0);

    // B3: out-of-range base reduced modulo DEPTH
    exp_b.push_back(8'd2); exp_b.push_back(8'd3); exp_b.push_back(8'd2);
    b_base = 4'd12; b_len = 5'd2; b_start = 1'b1;
    tick();
    b_start = 1'b0;
    cnt = 0;
    repeat (6) begin
      tick();
      if (b_done) cnt++;
    end
    check("b3_done_count", cnt, 1);
    b_abort = 1'b1;
    tick();
    b_abort = 1'b0;
    check("b3_busy", b_busy, 0);
    check("b3_queue_empty", exp_b.size(), 0);
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
